// File: rtl/osiris_pkg.sv
// Shared state encoding and default parameter values for the memory port arbiter.
package osiris_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ADDR_WIDTH    = 32;
  localparam int unsigned DEF_TIMEOUT       = 255;
  localparam int unsigned DEF_DM_STREAK_MAX = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUS_IF = 2'b01,
    BUS_DM = 2'b10
  } arb_state_e;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Bus-cycle wait counter: cleared at grant, counts wait cycles, flags expiry.
module arb_timeout_cnt import osiris_pkg::*; #(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned  CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;

  // Count wait cycles; hold at the limit so expiry stays up until the next clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expired = (r_cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single Wishbone master port.
// Data wins ties until it has starved a waiting fetch DM_STREAK_MAX times.
module mem_port_arbiter import osiris_pkg::*; #(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
  parameter int unsigned DM_STREAK_MAX = DEF_DM_STREAK_MAX
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_if_req,
  input  logic [ADDR_WIDTH-1:0]   i_if_addr,
  output logic                    o_if_ack,
  input  logic                    i_dm_req,
  input  logic                    i_dm_we,
  input  logic [DATA_WIDTH/8-1:0] i_dm_sel,
  input  logic [ADDR_WIDTH-1:0]   i_dm_addr,
  input  logic [DATA_WIDTH-1:0]   i_dm_wdata,
  output logic                    o_dm_ack,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_err,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int unsigned   SW         = DATA_WIDTH / 8;
  localparam int unsigned   KW         = (DM_STREAK_MAX < 1) ? 1 : $clog2(DM_STREAK_MAX + 1);
  localparam logic [KW-1:0] STREAK_MAX = KW'(DM_STREAK_MAX);

  arb_state_e              r_state, w_state_next;
  logic [KW-1:0]           r_streak, w_streak_next;
  logic                    r_cyc, r_we;
  logic [SW-1:0]           r_sel;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_dat;
  logic                    w_bus, w_done, w_expired;
  logic                    w_grant_if, w_grant_dm, w_grant;

  assign w_bus   = (r_state != IDLE);
  // A bus cycle ends on slave ack, slave error or wait-counter expiry.
  assign w_done  = w_bus && (wb_ack_i || wb_err_i || w_expired);
  assign w_grant = w_grant_if || w_grant_dm;

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_grant),
    .i_en      (w_bus && !wb_ack_i && !wb_err_i),
    .o_expired (w_expired)
  );

  // State register and starvation streak counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_next;
      r_streak <= w_streak_next;
    end
  end

  // Next state, grant decision, streak update and requester-side outputs.
  always_comb begin
    w_state_next  = r_state;
    w_streak_next = r_streak;
    w_grant_if    = 1'b0;
    w_grant_dm    = 1'b0;
    o_if_ack      = 1'b0;
    o_dm_ack      = 1'b0;
    o_err         = 1'b0;
    o_rdata       = '0;
    case (r_state)
      IDLE: begin
        if (i_dm_req && !(i_if_req && (r_streak == STREAK_MAX))) begin
          w_grant_dm   = 1'b1;
          w_state_next = BUS_DM;
          if (!i_if_req) begin
            w_streak_next = '0;
          end else if (r_streak != STREAK_MAX) begin
            w_streak_next = r_streak + KW'(1);
          end
        end else if (i_if_req) begin
          w_grant_if    = 1'b1;
          w_state_next  = BUS_IF;
          w_streak_next = '0;
        end
      end
      BUS_IF, BUS_DM: begin
        if (w_done) begin
          w_state_next = IDLE;
          o_if_ack     = (r_state == BUS_IF);
          o_dm_ack     = (r_state == BUS_DM);
          // Slave error beats ack; a bare expiry is also an error.
          o_err        = wb_err_i || !wb_ack_i;
          if (wb_ack_i || wb_err_i) begin
            o_rdata = wb_dat_i;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Wishbone request registers: loaded at grant, frozen for the whole bus cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
      r_sel <= '0;
      r_adr <= '0;
      r_dat <= '0;
    end else if (w_grant_dm) begin
      r_cyc <= 1'b1;
      r_we  <= i_dm_we;
      r_sel <= i_dm_sel;
      r_adr <= i_dm_addr;
      r_dat <= i_dm_wdata;
    end else if (w_grant_if) begin
      r_cyc <= 1'b1;
      r_we  <= 1'b0;
      r_sel <= '1;
      r_adr <= i_if_addr;
      r_dat <= '0;
    end else if (w_done) begin
      r_cyc <= 1'b0;
      r_we  <= 1'b0;
    end
  end

  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_we_o  = r_we;
  assign wb_sel_o = r_sel;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;

endmodule
